// File: rtl/display_pkg.sv
// Shared constants and FSM encoding for the four-digit scanned display
// and its binary-to-BCD converter.
package display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int BIN_W      = 14;
   localparam int ITER_COUNT = 14;
   localparam int MAX_VAL    = 9999;
   localparam int OVF_DIGIT  = 15;
   localparam int BCD_W      = NUM_DIGITS * DIGIT_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

endpackage

// File: rtl/display_scan_bin2bcd.sv
// Sequential double-dabble converter. One iteration per clock; the digit
// result register changes only when a conversion completes or overflows.
module bin2bcd
   import display_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [15:0]      bcd
);

   localparam int WORK_W = BCD_W + BIN_W;

   conv_state_t       state_reg, state_next;
   logic [3:0]        iter_reg, iter_next;
   logic [WORK_W-1:0] work_reg, work_next;
   logic [WORK_W-1:0] adjusted, shifted;
   logic [BCD_W-1:0]  result_reg, result_next;
   logic              in_range;

   // Add-3 correction on every BCD nibble of the working register.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adjust
         localparam int LSB = BIN_W + gi * DIGIT_W;
         assign adjusted[LSB +: DIGIT_W] =
            (work_reg[LSB +: DIGIT_W] >= DIGIT_W'(5)) ?
            work_reg[LSB +: DIGIT_W] + DIGIT_W'(3) : work_reg[LSB +: DIGIT_W];
      end
   endgenerate

   assign adjusted[BIN_W-1:0] = work_reg[BIN_W-1:0];
   assign shifted             = {adjusted[WORK_W-2:0], 1'b0};
   assign in_range            = (bin <= BIN_W'(MAX_VAL));

   always_comb begin
      state_next  = state_reg;
      iter_next   = iter_reg;
      work_next   = work_reg;
      result_next = result_reg;
      case (state_reg)
         IDLE, DONE: begin
            state_next = IDLE;
            if (start) begin
               if (in_range) begin
                  state_next = SHIFT;
                  iter_next  = '0;
                  work_next  = {{BCD_W{1'b0}}, bin};
               end else begin
                  state_next  = DONE;
                  result_next = {NUM_DIGITS{DIGIT_W'(OVF_DIGIT)}};
               end
            end
         end
         SHIFT: begin
            work_next = shifted;
            iter_next = iter_reg + 4'd1;
            if (iter_reg == 4'(ITER_COUNT - 1)) begin
               state_next  = DONE;
               result_next = shifted[WORK_W-1:BIN_W];
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         iter_reg   <= '0;
         work_reg   <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         iter_reg   <= iter_next;
         work_reg   <= work_next;
         result_reg <= result_next;
      end
   end

   // bcd shows the digits that will be held after the current edge, so the
   // scanner can register the new value on the same edge it takes effect.
   assign bcd  = result_next;
   assign busy = (state_reg == SHIFT);
   assign done = (state_reg == DONE);

endmodule

// File: rtl/display_scan.sv
// Four-digit display driver: converts a binary value to BCD and scans the
// digits out one at a time at REFRESH_DIV clocks per digit.
module display_scan
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] bin_in,
   input  logic        load,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [3:0]  num,
   output logic [1:0]  sw
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CNT_W-1:0]   refresh_reg, refresh_next;
   logic [1:0]         sw_reg, sw_next;
   logic [DIGIT_W-1:0] num_reg, num_next;
   logic               ovf_reg, ovf_next;
   logic               conv_busy, conv_done, accept, wrap;
   logic [BCD_W-1:0]   digits_next;

   assign accept = load & ~conv_busy;

   bin2bcd u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .bin   (bin_in),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (digits_next)
   );

   assign wrap = (refresh_reg == CNT_W'(REFRESH_DIV - 1));

   // num is looked up from the post-edge digits so it never lags an update.
   always_comb begin
      refresh_next = wrap ? '0 : refresh_reg + CNT_W'(1);
      sw_next      = wrap ? sw_reg + 2'd1 : sw_reg;
      num_next     = digits_next[{sw_next, 2'b00} +: DIGIT_W];
      ovf_next     = ovf_reg;
      if (accept) begin
         ovf_next = (bin_in > BIN_W'(MAX_VAL));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_reg <= '0;
         sw_reg      <= '0;
         num_reg     <= '0;
         ovf_reg     <= 1'b0;
      end else begin
         refresh_reg <= refresh_next;
         sw_reg      <= sw_next;
         num_reg     <= num_next;
         ovf_reg     <= ovf_next;
      end
   end

   assign busy = conv_busy;
   assign done = conv_done;
   assign ovf  = ovf_reg;
   assign num  = num_reg;
   assign sw   = sw_reg;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: directed scenarios plus random loads, every cycle
// compared against a decimal-arithmetic model of the display.
module tb_display_scan;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [13:0] bin_in;
   logic        busy, done, ovf;
   logic [3:0]  num;
   logic [1:0]  sw;

   int compared   = 0;
   int mismatched = 0;

   // reference model state
   int m_dig[4];
   int m_sw, m_cnt, m_left, m_pend;
   int m_done, m_ovf;

   display_scan #(.REFRESH_DIV(DIV)) dut (
      .clk    (clk),
      .rst    (rst),
      .bin_in (bin_in),
      .load   (load),
      .busy   (busy),
      .done   (done),
      .ovf    (ovf),
      .num    (num),
      .sw     (sw)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int nd;
      if (rst) begin
         for (int i = 0; i < 4; i++) m_dig[i] = 0;
         m_sw = 0; m_cnt = 0; m_left = 0; m_done = 0; m_ovf = 0;
      end else begin
         if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_sw  = (m_sw + 1) % 4;
         end else begin
            m_cnt++;
         end
         nd = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_dig[0] = m_pend % 10;
               m_dig[1] = (m_pend / 10) % 10;
               m_dig[2] = (m_pend / 100) % 10;
               m_dig[3] = m_pend / 1000;
               nd = 1;
            end
         end else if (load) begin
            if (int'(bin_in) > 9999) begin
               m_ovf = 1;
               for (int i = 0; i < 4; i++) m_dig[i] = 15;
               nd = 1;
            end else begin
               m_ovf  = 0;
               m_pend = int'(bin_in);
               m_left = 14;
            end
         end
         m_done = nd;
      end
   endtask

   // One clock: update the model on the rising edge, compare on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("busy", busy, (m_left > 0) ? 1 : 0);
      chk("done", done, m_done);
      chk("ovf",  ovf,  m_ovf);
      chk("sw",   sw,   m_sw);
      chk("num",  num,  m_dig[m_sw]);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         cycle();
         n++;
      end
      chk(tag, done, 1);
   endtask

   // Scan a full frame and check each position against fixed digits.
   task automatic scan_check(input string tag, input int d3, input int d2, input int d1, input int d0);
      int seen[4];
      int expd[4];
      expd[0] = d0; expd[1] = d1; expd[2] = d2; expd[3] = d3;
      for (int i = 0; i < 4; i++) seen[i] = -1;
      for (int i = 0; i < 4 * DIV; i++) begin
         cycle();
         seen[sw] = int'(num);
      end
      for (int i = 0; i < 4; i++) begin
         $display("%s: sw=%0d num=%0d expected %0d", tag, i, seen[i], expd[i]);
         chk(tag, seen[i], expd[i]);
      end
   endtask

   initial begin
      int bcount, changes, wrap_seen, prev_sw, val, gap, n;

      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      m_sw = 0; m_cnt = 0; m_left = 0; m_pend = 0; m_done = 0; m_ovf = 0;
      rst = 1'b1; load = 1'b0; bin_in = '0;

      // reset held for three cycles
      for (int i = 0; i < 3; i++) cycle();
      chk("rst_num", num, 0);
      chk("rst_sw", sw, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      $display("reset: num=%0d sw=%0d busy=%0d done=%0d ovf=%0d", num, sw, busy, done, ovf);
      rst = 1'b0;

      // 1234: busy for 14 cycles, then done, then scan 4,3,2,1
      load = 1'b1; bin_in = 14'd1234;
      cycle();
      load = 1'b0;
      bcount = busy ? 1 : 0;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         cycle();
         if (busy) bcount++;
         n++;
      end
      $display("load 1234: busy cycles=%0d done=%0d", bcount, done);
      chk("busy_len_1234", bcount, 14);
      chk("done_1234", done, 1);
      cycle();
      chk("done_one_cycle", done, 0);
      scan_check("scan_1234", 1, 2, 3, 4);

      // scan cadence: one advance every DIV cycles including the 3->0 wrap
      changes = 0; wrap_seen = 0; prev_sw = int'(sw);
      for (int i = 0; i < 4 * DIV; i++) begin
         cycle();
         if (int'(sw) != prev_sw) begin
            changes++;
            chk("sw_step", sw, (prev_sw + 1) % 4);
            if (prev_sw == 3 && sw == 2'd0) wrap_seen = 1;
         end
         prev_sw = int'(sw);
      end
      $display("scan cadence: changes=%0d wrap=%0d", changes, wrap_seen);
      chk("sw_changes", changes, 4);
      chk("sw_wrap", wrap_seen, 1);

      // overflow: no conversion, immediate done, all digits 15
      load = 1'b1; bin_in = 14'd10000;
      cycle();
      load = 1'b0;
      $display("load 10000: busy=%0d done=%0d ovf=%0d", busy, done, ovf);
      chk("ovf_busy", busy, 0);
      chk("ovf_done", done, 1);
      chk("ovf_flag", ovf, 1);
      scan_check("scan_ovf", 15, 15, 15, 15);

      // 9999 with a load of 5 during the third busy cycle
      load = 1'b1; bin_in = 14'd9999;
      cycle();
      load = 1'b0;
      cycle();
      cycle();
      chk("busy_third", busy, 1);
      load = 1'b1; bin_in = 14'd5;
      cycle();
      load = 1'b0;
      wait_done("done_9999");
      chk("ovf_clear", ovf, 0);
      scan_check("scan_9999", 9, 9, 9, 9);

      // reset at the 7th busy cycle of 4321 aborts the conversion
      load = 1'b1; bin_in = 14'd4321;
      cycle();
      load = 1'b0;
      for (int i = 0; i < 6; i++) cycle();
      chk("busy_seventh", busy, 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      $display("abort: busy=%0d done=%0d num=%0d", busy, done, num);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_num", num, 0);
      for (int i = 0; i < 20; i++) cycle();
      scan_check("scan_abort", 0, 0, 0, 0);
      load = 1'b1; bin_in = 14'd42;
      cycle();
      load = 1'b0;
      wait_done("done_42");
      scan_check("scan_42", 0, 0, 4, 2);

      // random loads, junk loads while busy, occasional reset
      for (int t = 0; t < 40; t++) begin
         gap = $urandom_range(0, 5);
         for (int i = 0; i < gap; i++) cycle();
         if ($urandom_range(0, 3) == 0) val = $urandom_range(10000, 16383);
         else val = $urandom_range(0, 9999);
         load = 1'b1; bin_in = 14'(val);
         cycle();
         n = 0;
         while (busy === 1'b1 && n < 30) begin
            load   = $urandom_range(0, 1);
            bin_in = 14'($urandom_range(0, 16383));
            rst    = ($urandom_range(0, 39) == 0);
            cycle();
            n++;
         end
         load = 1'b0; rst = 1'b0;
         chk("rand_not_stuck", busy, 0);
         $display("random load %0d: ovf=%0d digits=%0d%0d%0d%0d", val, ovf,
                  m_dig[3], m_dig[2], m_dig[1], m_dig[0]);
         for (int i = 0; i < 4 * DIV; i++) cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
